// File: rtl/opsum_drain_ctrl.sv
// opsum_drain_ctrl: fills the 4-deep opsum buffer from the reducer, then drains the active rows to the GLB
module opsum_drain_ctrl #(
  parameter int ROW_NUM = 32,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_pitch,
  input  logic [5:0]        cfg_row_en,
  input  logic [7:0]        cfg_tile_num,
  input  logic              red_valid,
  output logic              red_ready,
  output logic              store_opsum_f,
  output logic              glb_valid,
  input  logic              glb_ready,
  output logic [5:0]        rd_sel,
  output logic [ADDR_W-1:0] glb_addr,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
  state_t            state;
  logic [1:0]        fill_cnt;
  logic [5:0]        word_cnt;
  logic [5:0]        last_q;
  logic [7:0]        tile_idx;
  logic [7:0]        tile_num_q;
  logic [ADDR_W-1:0] tile_base;
  logic [ADDR_W-1:0] pitch_q;
  logic [6:0]        rows_c;
  logic [5:0]        last_c;
  // zero or oversized row counts fall back to the full buffer
  assign rows_c = (cfg_row_en == '0 || {1'b0, cfg_row_en} > 7'(ROW_NUM)) ? 7'(ROW_NUM) : {1'b0, cfg_row_en};
  assign last_c = 6'((rows_c << 1) - 7'd1);
  assign red_ready     = state == FILL;
  assign store_opsum_f = red_valid & red_ready;
  assign glb_valid     = state == DRAIN;
  assign rd_sel        = word_cnt;
  assign glb_addr      = glb_valid ? tile_base + ADDR_W'(word_cnt) : '0;
  assign busy          = state == FILL || state == DRAIN;
  assign done          = state == DONE;
  // sequencer: latch config, count stores per tile, then walk words and advance the tile base
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fill_cnt   <= '0;
      word_cnt   <= '0;
      last_q     <= '0;
      tile_idx   <= '0;
      tile_num_q <= '0;
      tile_base  <= '0;
      pitch_q    <= '0;
    end else begin
      case (state)
        IDLE: if (cfg_start) begin
          tile_base  <= cfg_base_addr;
          pitch_q    <= cfg_pitch;
          last_q     <= last_c;
          tile_num_q <= cfg_tile_num;
          fill_cnt   <= '0;
          word_cnt   <= '0;
          tile_idx   <= '0;
          state      <= cfg_tile_num == '0 ? DONE : FILL;
        end
        FILL: if (red_valid) begin
          fill_cnt <= fill_cnt + 2'd1;
          if (fill_cnt == 2'd3) state <= DRAIN;
        end
        DRAIN: if (glb_ready) begin
          if (word_cnt == last_q) begin
            word_cnt  <= '0;
            tile_base <= tile_base + pitch_q;
            tile_idx  <= tile_idx + 8'd1;
            state     <= tile_idx == tile_num_q - 8'd1 ? DONE : FILL;
          end else begin
            word_cnt <= word_cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_opsum_drain_ctrl.sv
// tb_opsum_drain_ctrl: directed checks of fill/drain sequencing, addressing, backpressure and abort
module tb_opsum_drain_ctrl;
  logic        clk = 0;
  logic        reset;
  logic        cfg_start;
  logic [15:0] cfg_base_addr;
  logic [15:0] cfg_pitch;
  logic [5:0]  cfg_row_en;
  logic [7:0]  cfg_tile_num;
  logic        red_valid;
  logic        red_ready;
  logic        store_opsum_f;
  logic        glb_valid;
  logic        glb_ready;
  logic [5:0]  rd_sel;
  logic [15:0] glb_addr;
  logic        busy;
  logic        done;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] addrs[$];

  opsum_drain_ctrl #(.ROW_NUM(32), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_pitch(cfg_pitch), .cfg_row_en(cfg_row_en), .cfg_tile_num(cfg_tile_num),
    .red_valid(red_valid), .red_ready(red_ready), .store_opsum_f(store_opsum_f),
    .glb_valid(glb_valid), .glb_ready(glb_ready), .rd_sel(rd_sel), .glb_addr(glb_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rr"}, 32'(red_ready), 0);
    chk({tag, "_st"}, 32'(store_opsum_f), 0);
    chk({tag, "_gv"}, 32'(glb_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_sel"}, 32'(rd_sel), 0);
    chk({tag, "_addr"}, 32'(glb_addr), 0);
  endtask

  // rvm: 0 red_valid always 1, 1 alternates 1,0; grm: 0 glb_ready always 1, 1 repeats 1,0,0,1
  task automatic run(input logic [15:0] b, input logic [15:0] p, input logic [5:0] re,
                     input logic [7:0] tn, input int rvm, input int grm, input bit poke,
                     input int exp_words, input int exp_done_cyc);
    int rows, last, phase, fc, w, t, stores, words, cyc;
    logic [15:0] base;
    bit fin;
    rows = (re == 0 || re > 32) ? 32 : int'(re);
    last = 2 * rows - 1;
    base = b; fc = 0; w = 0; t = 0; stores = 0; words = 0; fin = 0;
    phase = (tn == 0) ? 2 : 0;
    addrs.delete();
    cfg_base_addr = b; cfg_pitch = p; cfg_row_en = re; cfg_tile_num = tn;
    red_valid = 0; glb_ready = 0; cfg_start = 1;
    @(posedge clk); #1;
    cfg_start = 0;
    cyc = 1;
    while (!fin && cyc < 2000) begin
      red_valid = (rvm == 0) ? 1'b1 : (cyc % 2 == 1);
      glb_ready = (grm == 0) ? 1'b1 : (cyc % 4 == 1 || cyc % 4 == 0);
      cfg_start = poke && (cyc == 3 || cyc == 12);
      if (poke) begin
        cfg_base_addr = 16'hdead; cfg_pitch = 16'h7; cfg_row_en = 6'd1; cfg_tile_num = 8'd0;
      end
      #1;
      if (phase == 0) begin
        chk("fill_rr", 32'(red_ready), 1);
        chk("fill_gv", 32'(glb_valid), 0);
        chk("fill_st", 32'(store_opsum_f), 32'(red_valid));
        chk("fill_sel", 32'(rd_sel), 0);
        chk("fill_busy", 32'(busy), 1);
        chk("fill_done", 32'(done), 0);
        if (red_valid) begin
          stores++;
          fc++;
          if (fc == 4) begin phase = 1; fc = 0; end
        end
      end else if (phase == 1) begin
        chk("drain_rr", 32'(red_ready), 0);
        chk("drain_st", 32'(store_opsum_f), 0);
        chk("drain_gv", 32'(glb_valid), 1);
        chk("drain_sel", 32'(rd_sel), 32'(w));
        chk("drain_addr", 32'(glb_addr), 32'(16'(base + 16'(w))));
        chk("drain_busy", 32'(busy), 1);
        chk("drain_done", 32'(done), 0);
        if (glb_ready) begin
          words++;
          addrs.push_back(glb_addr);
          if (w == last) begin
            w = 0; base = base + p; t++;
            phase = (t == int'(tn)) ? 2 : 0;
          end else w++;
        end
      end else begin
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_gv", 32'(glb_valid), 0);
        chk("done_rr", 32'(red_ready), 0);
        if (exp_done_cyc >= 0) chk("done_cyc", 32'(cyc), 32'(exp_done_cyc));
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("run_finished", 32'(fin), 1);
    chk("stores", 32'(stores), 32'(4 * int'(tn)));
    chk("words", 32'(words), 32'(exp_words));
    cfg_start = 0; red_valid = 0; glb_ready = 0;
    @(posedge clk); #2;
    chk_idle("after_done");
  endtask

  initial begin
    reset = 1; cfg_start = 0; cfg_base_addr = 0; cfg_pitch = 0; cfg_row_en = 0;
    cfg_tile_num = 0; red_valid = 0; glb_ready = 0;
    repeat (2) @(posedge clk);
    #2;
    chk_idle("reset");
    reset = 0;
    @(posedge clk); #1;

    run(16'h0100, 16'h0040, 6'd32, 8'd1, 0, 0, 0, 64, 69);
    chk("basic_first", 32'(addrs[0]), 32'h0100);
    chk("basic_last", 32'(addrs[63]), 32'h013F);

    run(16'h0010, 16'h0008, 6'd3, 8'd2, 0, 0, 0, 12, 21);
    chk("part_t0_last", 32'(addrs[5]), 32'h0015);
    chk("part_t1_first", 32'(addrs[6]), 32'h0018);
    chk("part_t1_last", 32'(addrs[11]), 32'h001D);

    run(16'h0200, 16'h0010, 6'd5, 8'd2, 0, 1, 0, 20, -1);
    chk("bp_t1_first", 32'(addrs[10]), 32'h0210);

    run(16'h0300, 16'h0020, 6'd4, 8'd1, 1, 0, 0, 8, 16);

    run(16'h0400, 16'h0011, 6'd7, 8'd3, 1, 1, 0, 42, -1);
    chk("mix_t2_first", 32'(addrs[28]), 32'h0422);

    run(16'h0000, 16'h0040, 6'd0, 8'd1, 0, 0, 0, 64, 69);
    chk("row0_last", 32'(addrs[63]), 32'h003F);

    run(16'h1234, 16'h0001, 6'd4, 8'd0, 0, 0, 0, 0, 1);

    run(16'hFFFE, 16'h0004, 6'd2, 8'd1, 0, 0, 0, 4, 9);
    chk("wrap0", 32'(addrs[0]), 32'hFFFE);
    chk("wrap1", 32'(addrs[1]), 32'hFFFF);
    chk("wrap2", 32'(addrs[2]), 32'h0000);
    chk("wrap3", 32'(addrs[3]), 32'h0001);

    cfg_base_addr = 16'h0800; cfg_pitch = 16'h0040; cfg_row_en = 6'd32; cfg_tile_num = 8'd2;
    red_valid = 1; glb_ready = 1; cfg_start = 1;
    @(posedge clk); #1;
    cfg_start = 0;
    for (int i = 0; i < 200 && !(glb_valid && rd_sel == 6'd10); i++) begin
      @(posedge clk); #1;
    end
    #1;
    chk("abort_at_word", 32'(rd_sel), 10);
    chk("abort_gv", 32'(glb_valid), 1);
    reset = 1;
    @(posedge clk); #2;
    chk_idle("abort");
    reset = 0; red_valid = 1; glb_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk_idle("post_abort");
    end

    run(16'h0500, 16'h0040, 6'd32, 8'd1, 0, 0, 1, 64, 69);
    chk("restart_first", 32'(addrs[0]), 32'h0500);
    chk("restart_last", 32'(addrs[63]), 32'h053F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
